memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter.sv | 110 +++++++++++
 tb/tb_memory_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serialises instruction fetch and data access, alternating priority on ties.
// Grant one cycle after request; holds latched access until ACCESS, retries on ERROR, watchdog abort.
module memory_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t        state;
  logic          last_grant;
  logic          lat_wen;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_store;
  logic [CW-1:0] wdog;

  logic          dreq;
  logic          granted;
  logic          hit;
  logic          expired;
  logic          done;
  logic          icmp;
  logic          dcmp;
  logic [31:0]   cmpl_data;

  assign dreq      = dREN | dWEN;
  assign granted   = (state != IDLE);
  assign hit       = granted && (ramstate == RAM_ACCESS);
  // A real ACCESS in the expiry cycle still delivers the RAM data.
  assign expired   = granted && !hit && (wdog == CW'(TIMEOUT));
  assign done      = hit | expired;
  assign icmp      = done && (state == IGRANT);
  assign dcmp      = done && (state == DGRANT);
  assign cmpl_data = expired ? 32'hBAD1_BAD1 : ramload;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      lat_wen     <= 1'b0;
      lat_addr    <= '0;
      lat_store   <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (dreq && (!iREN || !last_grant)) begin
            state     <= DGRANT;
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wen   <= dWEN;
          end else if (iREN) begin
            state     <= IGRANT;
            lat_addr  <= iaddr;
            lat_store <= '0;
            lat_wen   <= 1'b0;
          end
        end
        default: begin
          if (done) begin
            state      <= IDLE;
            last_grant <= (state == DGRANT);
            wdog       <= '0;
            if (expired) timeout_err <= 1'b1;
          end else if (ramstate == RAM_ERROR) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + CW'(1);
          end
        end
      endcase
    end
  end

  assign ramREN   = granted && !lat_wen;
  assign ramWEN   = granted && lat_wen;
  assign ramaddr  = lat_addr;
  assign ramstore = lat_store;

  assign iwait = iREN && !icmp;
  assign dwait = dreq && !dcmp;
  assign iload = icmp ? cmpl_data : 32'h0;
  assign dload = dcmp ? cmpl_data : 32'h0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised scoreboard bench for memory_arbiter: a transaction-level model predicts grant order,
// grant/completion cycles, latched address and returned data; a monitor compares as the DUT presents them.
module tb_memory_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct packed {
    int          nw;    // cycles before ACCESS
    logic [31:0] err;   // bit j: cycle j answers ERROR
    logic [31:0] data;
  } plan_t;

  typedef struct packed {
    logic        side;  // 1 = data
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    int          start;
    int          endc;
    logic [31:0] load;
    logic        te;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        iwait, dwait, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    i_cmp = 0;
  int    d_cmp = 0;
  exp_t  expq[$];
  plan_t planq[$];
  bit    last_served = 1'b0;
  bit    sticky = 1'b0;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic plan_t mk_plan(input int nw, input logic [31:0] err, input logic [31:0] data);
    plan_t p;
    p.nw = nw;
    p.err = err;
    p.data = data;
    return p;
  endfunction

  // Granted cycles minus one until completion, from the watchdog rule.
  function automatic int grant_len(input plan_t p, output bit to);
    int run = 0;
    to = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (j == p.nw) return j;
      if (run == TO) begin
        to = 1'b1;
        return j;
      end
      run = (j < 32 && p.err[j[4:0]]) ? 0 : run + 1;
    end
    return 64;
  endfunction

  // RAM: answers each grant with the next plan in the queue
  initial begin
    plan_t cur;
    int    k = 0;
    bit    ps = 1'b0;
    bit    s;
    cur = mk_plan(0, 0, 0);
    ramstate = FREE;
    ramload = '0;
    forever begin
      @(posedge CLK);
      #1;
      s = ramREN | ramWEN;
      if (s && !ps) begin
        cur = (planq.size() > 0) ? planq.pop_front() : mk_plan(0, 0, 0);
        k = 0;
      end
      if (s) begin
        if (k == cur.nw) begin
          ramstate = ACCESS;
          ramload  = cur.data;
        end else begin
          ramstate = (k < 32 && cur.err[k[4:0]]) ? ERROR : ($urandom_range(0, 1) != 0 ? BUSY : FREE);
          ramload  = $urandom;
        end
        k++;
      end else begin
        ramstate = FREE;
        ramload  = $urandom;
      end
      ps = s;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    bit   ps = 1'b0;
    bit   strobe, icomp, dcomp;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        ps = 1'b0;
      end else begin
        strobe = ramREN | ramWEN;
        if (strobe) begin
          if (expq.size() == 0) begin
            chk("unexpected_grant", 32'(strobe), 0);
          end else begin
            e = expq[0];
            if (!ps) begin
              chk("grant_cycle", 32'(cyc), 32'(e.start));
              chk("ramWEN", 32'(ramWEN), 32'(e.wen));
              chk("ramREN", 32'(ramREN), 32'(!e.wen));
              if (e.wen) chk("ramstore", ramstore, e.store);
            end
            chk("ramaddr", ramaddr, e.addr);
          end
        end
        ps = strobe;
        icomp = iREN && !iwait;
        dcomp = (dREN || dWEN) && !dwait;
        if (icomp || dcomp) begin
          chk("single_completion", 32'(icomp && dcomp), 0);
          if (expq.size() == 0) begin
            chk("unexpected_completion", 32'(icomp || dcomp), 0);
          end else begin
            e = expq.pop_front();
            chk("cmpl_side", 32'(dcomp), 32'(e.side));
            chk("cmpl_cycle", 32'(cyc), 32'(e.endc));
            chk("cmpl_load", dcomp ? dload : iload, e.load);
            chk("timeout_err", 32'(timeout_err), 32'(e.te));
          end
          if (icomp) i_cmp++;
          if (dcomp) d_cmp++;
        end
        if (!icomp) chk("iload_idle", iload, 0);
        if (!dcomp) chk("dload_idle", dload, 0);
        if (!iREN) chk("iwait_noreq", 32'(iwait), 0);
        if (!(dREN || dWEN)) chk("dwait_noreq", 32'(dwait), 0);
      end
    end
  end

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #2;
    end
    expq.delete();
    planq.delete();
    last_served = 1'b0;
    sticky = 1'b0;
    nRST = 1'b1;
  endtask

  // mode: 0 instr only, 1 data only, 2 both
  task automatic run_scn(input int mode, input bit dren, input bit dwen,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                         input plan_t pi, input plan_t pd, input bit b2b);
    bit    has_i, has_d, first_d, side, to;
    int    t, start, len, ib, db;
    plan_t p;
    exp_t  e;
    if (!b2b) begin
      @(posedge CLK);
      #2;
    end
    has_i = (mode != 1);
    has_d = (mode != 0);
    if (has_d && !dren && !dwen) dren = 1'b1;
    t = cyc;
    ib = i_cmp;
    db = d_cmp;
    iREN = has_i;
    iaddr = ia;
    dREN = has_d && dren;
    dWEN = has_d && dwen;
    daddr = da;
    dstore = ds;
    first_d = has_d && (!has_i || !last_served);
    start = t + 1;
    for (int n = 0; n < int'(has_i) + int'(has_d); n++) begin
      side = (n == 0) ? first_d : !first_d;
      p = side ? pd : pi;
      len = grant_len(p, to);
      e.side = side;
      e.wen = side && dwen;
      e.addr = side ? da : ia;
      e.store = ds;
      e.start = start;
      e.endc = start + len;
      e.load = to ? 32'hBAD1_BAD1 : p.data;
      e.te = sticky;
      sticky = sticky | to;
      expq.push_back(e);
      planq.push_back(p);
      last_served = side;
      start = e.endc + 2;
    end
    for (int k = 0; k < 300; k++) begin
      if (!(iREN || dREN || dWEN)) break;
      @(posedge CLK);
      #2;
      if (k == 0) begin
        if (first_d) begin
          daddr = $urandom;
          dstore = $urandom;
        end else begin
          iaddr = $urandom;
        end
      end
      if (i_cmp != ib) iREN = 1'b0;
      if (d_cmp != db) begin
        dREN = 1'b0;
        dWEN = 1'b0;
      end
    end
    chk("complete_in_time", 32'(iREN || dREN || dWEN), 0);
    if (iREN || dREN || dWEN) do_reset();
  endtask

  initial begin
    int    r;
    exp_t  e;
    nRST = 1'b0;
    iREN = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 0);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    iREN = 1'b0;

    run_scn(0, 0, 0, 32'h0, 0, 0, mk_plan(0, 0, 32'h3C01_0001), mk_plan(0, 0, 0), 1'b1);
    run_scn(2, 0, 1, 32'h100, 32'h80, 32'hDEAD_BEEF, mk_plan(0, 0, 32'h11), mk_plan(0, 0, 32'h22), 1'b1);
    run_scn(2, 0, 1, 32'h104, 32'h84, 32'hCAFE_F00D, mk_plan(0, 0, 32'h33), mk_plan(0, 0, 32'h44), 1'b0);
    run_scn(1, 1, 0, 0, 32'h200, 0, mk_plan(0, 0, 0), mk_plan(3, 0, 32'h1234_5678), 1'b0);
    run_scn(0, 0, 0, 32'h300, 0, 0, mk_plan(2, 32'h3, 32'hA5A5_0001), mk_plan(0, 0, 0), 1'b1);
    run_scn(0, 0, 0, 32'h304, 0, 0, mk_plan(100, 0, 0), mk_plan(0, 0, 0), 1'b0);
    run_scn(0, 0, 0, 32'h308, 0, 0, mk_plan(7, 32'h8, 32'h0BAD_CAFE), mk_plan(0, 0, 0), 1'b1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 2);
      run_scn($urandom_range(0, 2), r != 1, r != 0, $urandom, $urandom, $urandom,
              mk_plan($urandom_range(0, 6), $urandom & $urandom & 32'hFF, $urandom),
              mk_plan($urandom_range(0, 6), $urandom & $urandom & 32'hFF, $urandom),
              $urandom_range(0, 1) != 0);
    end

    // leave last_grant on the data side, then abandon a data grant with reset
    run_scn(1, 1, 0, 0, 32'h500, 0, mk_plan(0, 0, 0), mk_plan(1, 0, 32'h5555_AAAA), 1'b0);
    @(posedge CLK);
    #2;
    dREN = 1'b1;
    daddr = 32'h400;
    planq.push_back(mk_plan(100, 0, 0));
    e.side = 1'b1;
    e.wen = 1'b0;
    e.addr = 32'h400;
    e.store = '0;
    e.start = cyc + 1;
    e.endc = 1_000_000;
    e.load = '0;
    e.te = sticky;
    expq.push_back(e);
    repeat (2) begin
      @(posedge CLK);
      #2;
    end
    nRST = 1'b0;
    @(negedge CLK);
    chk("pre_rst_ramREN", 32'(ramREN), 1);
    chk("pre_rst_timeout_err", 32'(timeout_err), 32'(sticky));
    @(posedge CLK);
    #2;
    dREN = 1'b0;
    @(negedge CLK);
    chk("midrst_ramREN", 32'(ramREN), 0);
    chk("midrst_ramWEN", 32'(ramWEN), 0);
    chk("midrst_timeout_err", 32'(timeout_err), 0);
    expq.delete();
    planq.delete();
    last_served = 1'b0;
    sticky = 1'b0;
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    run_scn(2, 1, 0, 32'h600, 32'h700, 0, mk_plan(0, 0, 32'h66), mk_plan(0, 0, 32'h77), 1'b1);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("queue_drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
